// File: rtl/fp_pkg.sv
// Shared floating-point helpers: field-width math, canonical qNaN, operand
// classes and the sqrt controller state encoding.
package fp_pkg;

  typedef enum logic [2:0] {
    ZERO,
    DENORM,
    NORMAL,
    INF,
    NAN
  } fp_class_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    RESP  = ST_RESP
  } sqrt_state_e;

  function automatic int fp_man_w(input int data_w, input int exp_w);
    return data_w - exp_w - 1;
  endfunction

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Positive sign, all-ones exponent, only the quiet bit of the mantissa set.
  function automatic logic [63:0] fp_qnan(input int data_w, input int exp_w);
    logic [63:0] q;
    q = 64'd0;
    for (int i = 0; i <= exp_w; i++) begin
      q[fp_man_w(data_w, exp_w) - 1 + i] = 1'b1;
    end
    return q;
  endfunction

endpackage

// File: rtl/fp_class.sv
// Combinational IEEE-754 operand classifier; sign is reported separately so
// callers decide what a negative operand means for their operation.
module fp_class
  import fp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8
) (
  input  logic [DATA_W-1:0] op,
  output fp_class_e         cls,
  output logic              sign
);

  localparam int MAN_W = fp_man_w(DATA_W, EXP_W);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign sign  = op[DATA_W-1];
  assign exp_f = op[DATA_W-2 -: EXP_W];
  assign man_f = op[MAN_W-1:0];

  always_comb begin
    cls = NORMAL;
    if (exp_f == '1) begin
      cls = (man_f != '0) ? NAN : INF;
    end else if (exp_f == '0) begin
      cls = (man_f != '0) ? DENORM : ZERO;
    end
  end

endmodule

// File: rtl/fp_sqrt_ctrl.sv
// Valid/ready wrapper around the iterative fp_sqrt core: special operands are
// answered locally, normal ones are issued to the core and the result captured.
module fp_sqrt_ctrl
  import fp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic              out_overflow,
  output logic              out_underflow,
  output logic              out_exception,
  output logic              core_start,
  output logic [DATA_W-1:0] core_op,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_res
);

  localparam logic [DATA_W-1:0] QNAN = DATA_W'(fp_qnan(DATA_W, EXP_W));

  sqrt_state_e       state;
  logic              first_wait;
  fp_class_e         in_cls;
  logic              in_sign;
  logic              byp_hit;
  logic [DATA_W-1:0] byp_res;
  logic              byp_unf;
  logic              byp_exc;

  fp_class #(
    .DATA_W(DATA_W),
    .EXP_W (EXP_W)
  ) u_class (
    .op  (in_op),
    .cls (in_cls),
    .sign(in_sign)
  );

  // Bypass result for operands that never reach the core.
  always_comb begin
    byp_hit = 1'b1;
    byp_res = in_op;
    byp_unf = 1'b0;
    byp_exc = 1'b0;
    case (in_cls)
      NAN: begin
        byp_res = QNAN;
        byp_exc = 1'b1;
      end
      ZERO: byp_res = in_op;
      DENORM: begin
        byp_res = {in_sign, {(DATA_W-1){1'b0}}};
        byp_unf = 1'b1;
      end
      default: begin
        if (in_sign) begin
          byp_res = QNAN;
          byp_exc = 1'b1;
        end else if (in_cls == NORMAL) begin
          byp_hit = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      first_wait    <= 1'b0;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      out_res       <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_exception <= 1'b0;
      core_start    <= 1'b0;
      core_op       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_ready && in_valid) begin
            in_ready <= 1'b0;
            core_op  <= in_op;
            if (byp_hit) begin
              out_res       <= byp_res;
              out_overflow  <= 1'b0;
              out_underflow <= byp_unf;
              out_exception <= byp_exc;
              out_valid     <= 1'b1;
              state         <= RESP;
            end else begin
              core_start <= 1'b1;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          core_start <= 1'b0;
          first_wait <= 1'b1;
          state      <= WAIT;
        end
        // core_done is still high from the previous operation in the first cycle.
        WAIT: begin
          if (first_wait) begin
            first_wait <= 1'b0;
          end else if (core_done) begin
            out_res       <= core_res;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_exception <= 1'b0;
            out_valid     <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
